// File: rtl/rca_bist_repair.sv
// Self-repairing ripple-carry adder: WIDTH logical bits on WIDTH+1 full adders.
// A built-in self-test exercises every full adder and bypasses one faulty stage.
module rca_bist_repair #(
    parameter  int WIDTH = 4,
    localparam int IDXW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    input  logic             bist_start,
    output logic             busy,
    output logic             bist_done,
    output logic [WIDTH:0]   fault_map,
    output logic             repaired,
    output logic [IDXW-1:0]  repair_idx,
    output logic             bist_fail,
    input  logic [WIDTH:0]   fault_inj_mask,
    input  logic [1:0]       fault_inj_mode
);

    localparam int N  = WIDTH + 1;
    localparam int CW = IDXW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TEST,
        S_EVAL,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       pat_q;
    logic [N-1:0]     fault_map_q;
    logic             byp_en_q;
    logic [IDXW-1:0]  byp_idx_q;
    logic             bist_fail_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_cout_q;

    logic             test;
    logic [N-1:0]     lo_mask;
    logic [N-1:0]     ext_a, ext_b;
    logic [N-1:0]     pa, pb;
    logic [N-1:0]     fsum, fcar;
    logic [N-1:0]     fail_vec;
    logic             exp_s, exp_c;
    logic [WIDTH-1:0] lsum;
    logic             lcout;
    logic [CW-1:0]    nflt;
    logic [IDXW-1:0]  fidx;

    // One physical full adder with the stuck-at fault applied to its outputs
    function automatic logic [1:0] fa_cell(
        input logic       a,
        input logic       b,
        input logic       c,
        input logic       inj,
        input logic [1:0] mode
    );
        logic s, cy;
        s  = a ^ b ^ c;
        cy = (a & b) | (a & c) | (b & c);
        if (inj) begin
            unique case (mode)
                2'b00:   s  = 1'b0;
                2'b01:   s  = 1'b1;
                2'b10:   cy = 1'b0;
                default: cy = 1'b1;
            endcase
        end
        return {cy, s};
    endfunction

    assign test = (state_q == S_TEST);

    // Bits below the bypassed stage stay put, bits at or above it move up by one
    always_comb begin
        lo_mask = '1;
        if (byp_en_q) lo_mask = (N'(1) << byp_idx_q) - N'(1);
    end

    assign ext_a = {1'b0, in_a};
    assign ext_b = {1'b0, in_b};
    assign pa    = (ext_a & lo_mask) | ((ext_a & ~lo_mask) << 1);
    assign pb    = (ext_b & lo_mask) | ((ext_b & ~lo_mask) << 1);

    always_comb begin
        logic       c;
        logic [1:0] r;
        c    = in_cin;
        fsum = '0;
        fcar = '0;
        for (int i = 0; i < N; i++) begin
            if (test)
                r = fa_cell(pat_q[2], pat_q[1], pat_q[0],
                            fault_inj_mask[i], fault_inj_mode);
            else
                r = fa_cell(pa[i], pb[i], c,
                            fault_inj_mask[i], fault_inj_mode);
            fsum[i] = r[0];
            fcar[i] = r[1];
            // A bypassed stage passes its incoming carry straight through
            if (!(byp_en_q && byp_idx_q == IDXW'(i))) c = r[1];
        end
    end

    assign lsum  = (fsum[WIDTH-1:0] & lo_mask[WIDTH-1:0])
                 | (fsum[WIDTH:1] & ~lo_mask[WIDTH-1:0]);
    assign lcout = byp_en_q ? fcar[WIDTH] : fcar[WIDTH-1];

    assign exp_s    = ^pat_q;
    assign exp_c    = (pat_q[2] & pat_q[1]) | (pat_q[2] & pat_q[0])
                    | (pat_q[1] & pat_q[0]);
    assign fail_vec = (fsum ^ {N{exp_s}}) | (fcar ^ {N{exp_c}});

    always_comb begin
        nflt = '0;
        fidx = '0;
        for (int i = 0; i < N; i++) begin
            if (fault_map_q[i]) begin
                nflt = nflt + CW'(1);
                fidx = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bist_start) state_d = S_TEST;
            S_TEST:  if (pat_q == 3'd7) state_d = S_EVAL;
            S_EVAL:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        bist_done = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q       <= '0;
            fault_map_q <= '0;
            byp_en_q    <= 1'b0;
            byp_idx_q   <= '0;
            bist_fail_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
        end else begin
            out_valid_q <= in_valid && in_ready;
            if (in_valid && in_ready) begin
                out_sum_q  <= lsum;
                out_cout_q <= lcout;
            end
            if (in_ready && bist_start) begin
                fault_map_q <= '0;
                pat_q       <= '0;
            end
            if (test) begin
                fault_map_q <= fault_map_q | fail_vec;
                pat_q       <= pat_q + 3'd1;
            end
            if (state_q == S_EVAL) begin
                byp_en_q    <= 1'b0;
                byp_idx_q   <= '0;
                bist_fail_q <= 1'b0;
                if (nflt == CW'(1) && fidx < IDXW'(WIDTH)) begin
                    byp_en_q  <= 1'b1;
                    byp_idx_q <= fidx;
                end else if (nflt >= CW'(2)) begin
                    bist_fail_q <= 1'b1;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sum    = out_sum_q;
    assign out_cout   = out_cout_q;
    assign fault_map  = fault_map_q;
    assign repaired   = byp_en_q;
    assign repair_idx = byp_idx_q;
    assign bist_fail  = bist_fail_q;

endmodule

// File: tb/tb_rca_bist_repair.sv
// Bench for rca_bist_repair: directed vectors, literal checks and a
// cycle-level behavioural model compared on every falling edge.
module tb_rca_bist_repair;

    localparam int W  = 4;
    localparam int IW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b;
    logic          in_cin;
    logic          out_valid;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          bist_start;
    logic          busy;
    logic          bist_done;
    logic [W:0]    fault_map;
    logic          repaired;
    logic [IW-1:0] repair_idx;
    logic          bist_fail;
    logic [W:0]    fault_inj_mask;
    logic [1:0]    fault_inj_mode;

    always #5 clk = ~clk;

    rca_bist_repair #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_cin        (in_cin),
        .out_valid     (out_valid),
        .out_sum       (out_sum),
        .out_cout      (out_cout),
        .bist_start    (bist_start),
        .busy          (busy),
        .bist_done     (bist_done),
        .fault_map     (fault_map),
        .repaired      (repaired),
        .repair_idx    (repair_idx),
        .bist_fail     (bist_fail),
        .fault_inj_mask(fault_inj_mask),
        .fault_inj_mode(fault_inj_mode)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] fa_model(input logic a, input logic b,
                                            input logic c, input logic inj,
                                            input logic [1:0] mode);
        int   t;
        logic s, cy;
        t  = int'(a) + int'(b) + int'(c);
        s  = (t % 2) == 1;
        cy = t >= 2;
        if (inj) begin
            case (mode)
                2'b00:   s  = 1'b0;
                2'b01:   s  = 1'b1;
                2'b10:   cy = 1'b0;
                default: cy = 1'b1;
            endcase
        end
        return {cy, s};
    endfunction

    function automatic logic [W:0] model_add(
        input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
        input logic [W:0] mask, input logic [1:0] mode,
        input logic rep, input logic [IW-1:0] idx);
        logic [W-1:0] s;
        logic         c;
        logic [1:0]   r;
        int           p;
        c = ci;
        s = '0;
        for (int j = 0; j < W; j++) begin
            p    = (rep && j >= int'(idx)) ? j + 1 : j;
            r    = fa_model(a[j], b[j], c, mask[p], mode);
            s[j] = r[0];
            c    = r[1];
        end
        return {c, s};
    endfunction

    function automatic logic [W:0] exp_map(input logic [W:0] mask,
                                           input logic [1:0] mode);
        logic [W:0] m;
        logic [1:0] r;
        int         t;
        m = '0;
        for (int i = 0; i <= W; i++) begin
            for (int p = 0; p < 8; p++) begin
                t = (p & 1) + ((p >> 1) & 1) + ((p >> 2) & 1);
                r = fa_model(p[2], p[1], p[0], mask[i], mode);
                if (r[0] != ((t % 2) == 1) || r[1] != (t >= 2)) m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [IW-1:0] low_idx(input logic [W:0] m);
        for (int i = 0; i <= W; i++) if (m[i]) return IW'(i);
        return '0;
    endfunction

    logic [W:0]    fm_now;
    logic [W:0]    sum_now;
    logic          m_live = 1'b0;
    int            m_cnt;
    logic          m_ov, m_cout, m_rep, m_fail;
    logic [W-1:0]  m_sum;
    logic [W:0]    m_map;
    logic [IW-1:0] m_idx;

    assign fm_now  = exp_map(fault_inj_mask, fault_inj_mode);
    assign sum_now = model_add(in_a, in_b, in_cin, fault_inj_mask,
                               fault_inj_mode, m_rep, m_idx);

    always @(posedge clk) begin
        m_live <= 1'b1;
        if (!rst_n) begin
            m_cnt  <= 0;
            m_ov   <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_map  <= '0;
            m_rep  <= 1'b0;
            m_idx  <= '0;
            m_fail <= 1'b0;
        end else if (m_cnt == 0) begin
            m_ov <= in_valid;
            if (in_valid) begin
                m_sum  <= sum_now[W-1:0];
                m_cout <= sum_now[W];
            end
            if (bist_start) m_cnt <= 10;
        end else begin
            m_ov  <= 1'b0;
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
                m_map  <= fm_now;
                m_rep  <= ($countones(fm_now) == 1) && !fm_now[W];
                m_idx  <= (($countones(fm_now) == 1) && !fm_now[W])
                          ? low_idx(fm_now) : '0;
                m_fail <= $countones(fm_now) >= 2;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_ready", in_ready, m_cnt == 0);
            chk("m_busy", busy, m_cnt != 0);
            chk("m_done", bist_done, m_cnt == 1);
            chk("m_valid", out_valid, m_ov);
            chk("m_sum", out_sum, m_sum);
            chk("m_cout", out_cout, m_cout);
            if (m_cnt <= 1) begin
                chk("m_map", fault_map, m_map);
                chk("m_rep", repaired, m_rep);
                chk("m_idx", repair_idx, m_idx);
                chk("m_fail", bist_fail, m_fail);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic [W-1:0] es,
                      input logic ec, input string nm);
        in_a     = a;
        in_b     = b;
        in_cin   = ci;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_sum"}, out_sum, es);
        chk({nm, "_cout"}, out_cout, ec);
    endtask

    task automatic run_bist(input logic [W:0] em, input logic er,
                            input logic [IW-1:0] ei, input logic ef,
                            input string nm);
        int k;
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        in_valid   = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            bist_start = (k == 4);
        end while (!bist_done && k < 20);
        bist_start = 1'b0;
        chk({nm, "_latency"}, k, 10);
        chk({nm, "_map"}, fault_map, em);
        chk({nm, "_rep"}, repaired, er);
        chk({nm, "_idx"}, repair_idx, ei);
        chk({nm, "_fail"}, bist_fail, ef);
        @(negedge clk);
        chk({nm, "_ready"}, in_ready, 1);
    endtask

    initial begin
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_a           = '0;
        in_b           = '0;
        in_cin         = 1'b0;
        bist_start     = 1'b0;
        fault_inj_mask = '0;
        fault_inj_mode = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_map", fault_map, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_sum", out_sum, 0);

        op(4'd7, 4'd9, 1'b1, 4'h1, 1'b1, "t1");

        in_a     = 4'd7;
        in_b     = 4'd9;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        run_bist(5'b00000, 1'b0, '0, 1'b0, "t2");

        fault_inj_mask = 5'b00010;
        fault_inj_mode = 2'b00;
        op(4'd2, 4'd0, 1'b0, 4'h0, 1'b0, "t3_pre");
        run_bist(5'b00010, 1'b1, 3'd1, 1'b0, "t3");
        op(4'd2, 4'd0, 1'b0, 4'h2, 1'b0, "t3_a");
        op(4'd15, 4'd15, 1'b1, 4'hF, 1'b1, "t3_b");
        op(4'd5, 4'd6, 1'b0, 4'hB, 1'b0, "t3_c");

        fault_inj_mask = 5'b10000;
        fault_inj_mode = 2'b11;
        run_bist(5'b10000, 1'b0, '0, 1'b0, "t4");
        op(4'd15, 4'd1, 1'b0, 4'h0, 1'b1, "t4_a");

        fault_inj_mask = 5'b00101;
        fault_inj_mode = 2'b01;
        run_bist(5'b00101, 1'b0, '0, 1'b1, "t5");
        op(4'd0, 4'd0, 1'b0, 4'h5, 1'b0, "t5_a");

        fault_inj_mask = 5'b00010;
        fault_inj_mode = 2'b00;
        run_bist(5'b00010, 1'b1, 3'd1, 1'b0, "t6_pre");
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_map", fault_map, 0);
        chk("t6_rep", repaired, 0);
        chk("t6_idx", repair_idx, 0);
        chk("t6_fail", bist_fail, 0);
        op(4'd2, 4'd0, 1'b0, 4'h0, 1'b0, "t6_a");

        fault_inj_mask = '0;
        op(4'd8, 4'd8, 1'b0, 4'h0, 1'b1, "t7_a");
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
